// File: rtl/traffic_ctrl_multi_pkg.sv
// Shared lamp encoding, controller states and the round-robin next-phase search
// for the multi-approach traffic controller.
package traffic_pkg;

  localparam logic [1:0] LAMP_RED    = 2'd0;
  localparam logic [1:0] LAMP_GREEN  = 2'd1;
  localparam logic [1:0] LAMP_YELLOW = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GREEN,
    ST_YELLOW,
    ST_ALLRED,
    ST_WALK
  } state_t;

  // First approach after cur (wrapping, cur itself checked last) with demand;
  // falls back to cur+1 when nobody is waiting. n is the approach count (2..8).
  function automatic logic [2:0] next_phase(input logic [7:0] dem,
                                            input logic [2:0] cur,
                                            input int         n);
    int         idx;
    logic       found;
    logic [2:0] res;
    idx   = (int'(cur) + 1) % n;
    res   = idx[2:0];
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k <= n && !found) begin
        idx = (int'(cur) + k) % n;
        if (dem[idx[2:0]]) begin
          res   = idx[2:0];
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/traffic_ctrl_multi_if.sv
// Controller-facing bundle: run/demand/pedestrian inputs and lamp/status outputs.
// Inputs are level signals sampled on every rising clock edge; there is no handshake.
interface traffic_ctrl_multi_if #(parameter int N_DIR = 4);
  import traffic_pkg::*;
  localparam int PW = $clog2(N_DIR);

  logic               enable;
  logic [N_DIR-1:0]   demand;
  logic               ped_req;
  logic [2*N_DIR-1:0] light;
  logic [PW-1:0]      phase;
  logic               walk;
  logic               busy;
  state_t             state_dbg;

  modport master (output enable, demand, ped_req,
                  input  light, phase, walk, busy, state_dbg);
  modport slave  (input  enable, demand, ped_req,
                  output light, phase, walk, busy, state_dbg);
endinterface

// File: rtl/tl_phase_timer.sv
// Down-counter for timed controller states: load D-1, expire pulses in the
// final cycle of the D-cycle interval, then the timer idles until reloaded.
module tl_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);
  logic [CNT_W-1:0] cnt;
  logic             running;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (load) begin
      cnt     <= load_val;
      running <= 1'b1;
    end else if (running) begin
      if (cnt == '0) running <= 1'b0;
      else           cnt     <= cnt - 1'b1;
    end
  end

  assign expire = running && (cnt == '0);
endmodule

// File: rtl/traffic_ctrl_multi.sv
// Actuated N-approach traffic controller with green extension, empty-phase skip
// and safe shutdown. Define TRAFFIC_PED_WALK_EN to build the pedestrian WALK phase.
module traffic_ctrl_multi
  import traffic_pkg::*;
#(
  parameter int N_DIR        = 4,
  parameter int GREEN_TIME   = 8,
  parameter int MAX_GREEN    = 16,
  parameter int YELLOW_TIME  = 3,
  parameter int ALL_RED_TIME = 1,
  parameter int WALK_TIME    = 6,
  parameter int CNT_W        = 8
) (
  input logic                clk,
  input logic                rst,
  traffic_ctrl_multi_if.slave bus
);
  localparam int PW = $clog2(N_DIR);

  state_t             state_q, state_n;
  logic [PW-1:0]      phase_q, phase_n;
  logic [CNT_W-1:0]   gcnt_q, gcnt_n;
  logic               ext_q, ext_n, shut_q, shut_n;
  logic [2*N_DIR-1:0] light_q, light_n;
  logic               walk_q, busy_q;
  logic               tmr_load, tmr_expire, walk_entry, ped_pend, stop, solo;
  logic               go_green, go_yellow;
  logic [CNT_W-1:0]   tmr_val;
  logic [2:0]         np;

  tl_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk), .rst(rst), .load(tmr_load), .load_val(tmr_val), .expire(tmr_expire)
  );

`ifdef TRAFFIC_PED_WALK_EN
  // A request coinciding with WALK entry is kept so it is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ped_pend <= 1'b0;
    else     ped_pend <= (ped_pend & ~walk_entry) | bus.ped_req;
  end
`else
  logic unused_ped;
  assign unused_ped = bus.ped_req ^ walk_entry;
  assign ped_pend   = 1'b0;
`endif

  always_comb begin
    state_n    = state_q;
    phase_n    = phase_q;
    gcnt_n     = gcnt_q;
    ext_n      = ext_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    walk_entry = 1'b0;
    go_green   = 1'b0;
    go_yellow  = 1'b0;
    stop       = shut_q | ~bus.enable;
    solo       = (bus.demand == (N_DIR'(1) << phase_q));
    np         = next_phase(8'(bus.demand), 3'(phase_q), N_DIR);
    case (state_q)
      ST_IDLE: if (bus.enable) go_green = 1'b1;
      ST_GREEN: begin
        if (!bus.enable) begin
          go_yellow = 1'b1;
        end else if (tmr_expire || ext_q) begin
          if (solo && gcnt_q < CNT_W'(MAX_GREEN)) begin
            ext_n  = 1'b1;
            gcnt_n = gcnt_q + 1'b1;
          end else begin
            go_yellow = 1'b1;
          end
        end else begin
          gcnt_n = gcnt_q + 1'b1;
        end
      end
      ST_YELLOW: if (tmr_expire) begin
        state_n  = ST_ALLRED;
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(ALL_RED_TIME - 1);
      end
      ST_ALLRED, ST_WALK: if (tmr_expire) begin
        if (stop) begin
          state_n = ST_IDLE;
          phase_n = '0;
        end else if (state_q == ST_ALLRED && ped_pend) begin
          state_n    = ST_WALK;
          walk_entry = 1'b1;
          tmr_load   = 1'b1;
          tmr_val    = CNT_W'(WALK_TIME - 1);
        end else begin
          go_green = 1'b1;
          phase_n  = np[PW-1:0];
        end
      end
      default: begin
        state_n = ST_IDLE;
        phase_n = '0;
      end
    endcase
    if (go_green) begin
      state_n  = ST_GREEN;
      tmr_load = 1'b1;
      tmr_val  = CNT_W'(GREEN_TIME - 1);
      gcnt_n   = CNT_W'(1);
      ext_n    = 1'b0;
      if (state_q == ST_IDLE) phase_n = '0;
    end
    if (go_yellow) begin
      state_n  = ST_YELLOW;
      tmr_load = 1'b1;
      tmr_val  = CNT_W'(YELLOW_TIME - 1);
    end
  end

  // Shutdown latches once enable drops mid-sequence; only IDLE clears it.
  always_comb begin
    shut_n = shut_q;
    if (state_n == ST_IDLE)                      shut_n = 1'b0;
    else if (state_q != ST_IDLE && !bus.enable) shut_n = 1'b1;
    light_n = '0;
    if (state_n == ST_GREEN)  light_n[2*int'(phase_n) +: 2] = LAMP_GREEN;
    if (state_n == ST_YELLOW) light_n[2*int'(phase_n) +: 2] = LAMP_YELLOW;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      gcnt_q  <= '0;
      ext_q   <= 1'b0;
      shut_q  <= 1'b0;
      light_q <= '0;
      walk_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      phase_q <= phase_n;
      gcnt_q  <= gcnt_n;
      ext_q   <= ext_n;
      shut_q  <= shut_n;
      light_q <= light_n;
      walk_q  <= (state_n == ST_WALK);
      busy_q  <= (state_n != ST_IDLE);
    end
  end

  assign bus.light     = light_q;
  assign bus.phase     = phase_q;
  assign bus.walk      = walk_q;
  assign bus.busy      = busy_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Bench for traffic_ctrl_multi: a 2-approach and a 4-approach instance, table
// vectors, hand sequences for corner cases and a randomized model comparison.
module tb_traffic_ctrl_multi;
  localparam int G = 3, MAXG = 5, Y = 1, AR = 1, W = 2;
  localparam int MI = 0, MG = 1, MY = 2, MA = 3, MW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  traffic_ctrl_multi_if #(.N_DIR(2)) b2 ();
  traffic_ctrl_multi_if #(.N_DIR(4)) b4 ();

  traffic_ctrl_multi #(.N_DIR(2), .GREEN_TIME(G), .MAX_GREEN(MAXG), .YELLOW_TIME(Y),
                       .ALL_RED_TIME(AR), .WALK_TIME(W), .CNT_W(8))
    dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
  traffic_ctrl_multi #(.N_DIR(4), .GREEN_TIME(G), .MAX_GREEN(MAXG), .YELLOW_TIME(Y),
                       .ALL_RED_TIME(AR), .WALK_TIME(W), .CNT_W(8))
    dut4 (.clk(clk), .rst(rst), .bus(b4.slave));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    b2.enable = 1'b0; b2.demand = '0; b2.ped_req = 1'b0;
    b4.enable = 1'b0; b4.demand = '0; b4.ped_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reference model for the 4-approach instance: mode + elapsed-cycle count.
  int   m_mode, m_el, m_ph;
  bit   m_pend, m_stop;

  function automatic int pick_next(input logic [3:0] dem, input int cur);
    for (int k = 1; k <= 4; k++)
      if (dem[(cur + k) % 4]) return (cur + k) % 4;
    return (cur + 1) % 4;
  endfunction

  task automatic model_reset();
    m_mode = MI; m_el = 0; m_ph = 0; m_pend = 0; m_stop = 0;
  endtask

  task automatic model_step(input bit en, input logic [3:0] dem, input bit ped);
    bit stop_now;
    int prev;
    stop_now = m_stop || !en;
    prev = m_mode;
    case (m_mode)
      MI: if (en) begin m_mode = MG; m_el = 1; m_ph = 0; end
      MG: begin
        if (!en) begin m_mode = MY; m_el = 1; end
        else if (m_el < G || (dem == (4'b0001 << m_ph) && m_el < MAXG)) m_el++;
        else begin m_mode = MY; m_el = 1; end
      end
      MY: if (m_el < Y) m_el++; else begin m_mode = MA; m_el = 1; end
      MA, MW: begin
        if (m_el < ((m_mode == MA) ? AR : W)) m_el++;
        else if (stop_now) begin m_mode = MI; m_ph = 0; end
        else if (m_mode == MA && m_pend) begin m_mode = MW; m_el = 1; m_pend = 0; end
        else begin m_mode = MG; m_el = 1; m_ph = pick_next(dem, m_ph); end
      end
      default: m_mode = MI;
    endcase
    if (m_mode == MI) m_stop = 0;
    else if (prev != MI && !en) m_stop = 1;
`ifdef TRAFFIC_PED_WALK_EN
    if (ped) m_pend = 1;
`else
    if (ped) m_pend = 0;
`endif
  endtask

  function automatic logic [7:0] model_light();
    logic [7:0] r;
    r = '0;
    if (m_mode == MG) r[2*m_ph +: 2] = 2'd1;
    if (m_mode == MY) r[2*m_ph +: 2] = 2'd2;
    return r;
  endfunction

  typedef struct {
    logic       en;
    logic [1:0] dem;
    logic [3:0] light;
    logic       ph;
    logic       busy;
  } vec_t;

  vec_t tv[11];
  logic [3:0] ext_exp[8];
  logic [3:0] ped_light[7];
  logic       ped_walk[7];
  logic [1:0] served[$];
  logic [1:0] exp_srv[4];

  initial begin
    tv[0]  = '{1'b1, 2'b11, 4'b0001, 1'b0, 1'b1};
    tv[1]  = '{1'b1, 2'b11, 4'b0001, 1'b0, 1'b1};
    tv[2]  = '{1'b1, 2'b11, 4'b0001, 1'b0, 1'b1};
    tv[3]  = '{1'b1, 2'b11, 4'b0010, 1'b0, 1'b1};
    tv[4]  = '{1'b1, 2'b11, 4'b0000, 1'b0, 1'b1};
    tv[5]  = '{1'b1, 2'b11, 4'b0100, 1'b1, 1'b1};
    tv[6]  = '{1'b1, 2'b11, 4'b0100, 1'b1, 1'b1};
    tv[7]  = '{1'b1, 2'b11, 4'b0100, 1'b1, 1'b1};
    tv[8]  = '{1'b1, 2'b11, 4'b1000, 1'b1, 1'b1};
    tv[9]  = '{1'b1, 2'b11, 4'b0000, 1'b1, 1'b1};
    tv[10] = '{1'b1, 2'b11, 4'b0001, 1'b0, 1'b1};
    ext_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0000, 4'b0001};
`ifdef TRAFFIC_PED_WALK_EN
    ped_light = '{4'b0001, 4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
    ped_walk  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
`else
    ped_light = '{4'b0001, 4'b0001, 4'b0010, 4'b0000, 4'b0100, 4'b0100, 4'b0100};
    ped_walk  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    exp_srv = '{2'd0, 2'd3, 2'd0, 2'd3};

    // Reset values
    do_reset();
    check("rst_light2", b2.light, 0);  check("rst_phase2", b2.phase, 0);
    check("rst_walk2", b2.walk, 0);    check("rst_busy2", b2.busy, 0);
    check("rst_light4", b4.light, 0);  check("rst_busy4", b4.busy, 0);

    // Round robin, table driven
    for (int i = 0; i < 11; i++) begin
      b2.enable = tv[i].en;
      b2.demand = tv[i].dem;
      tick();
      check($sformatf("rr_light[%0d]", i), b2.light, tv[i].light);
      check($sformatf("rr_phase[%0d]", i), b2.phase, tv[i].ph);
      check($sformatf("rr_busy[%0d]", i), b2.busy, tv[i].busy);
    end

    // Asynchronous reset in approach-1 green
    do_reset();
    b2.enable = 1'b1; b2.demand = 2'b11;
    repeat (7) tick();
    check("pre_rst_phase", b2.phase, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_light", b2.light, 0); check("async_rst_phase", b2.phase, 0);
    check("async_rst_busy", b2.busy, 0);   check("async_rst_walk", b2.walk, 0);
    b2.enable = 1'b0;
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_idle_busy", b2.busy, 0);
      check("rst_idle_light", b2.light, 0);
    end

    // Green extension with a single requesting approach
    do_reset();
    b2.enable = 1'b1; b2.demand = 2'b01;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("ext_light[%0d]", i), b2.light, ext_exp[i]);
    end

    // Shutdown, re-assert during yellow must not abort it
    do_reset();
    b2.enable = 1'b1; b2.demand = 2'b11;
    tick(); tick();
    b2.enable = 1'b0;
    tick(); check("sd_yellow", b2.light, 4'b0010);
    b2.enable = 1'b1;
    tick(); check("sd_allred_light", b2.light, 0); check("sd_allred_busy", b2.busy, 1);
    tick(); check("sd_idle_busy", b2.busy, 0);     check("sd_idle_light", b2.light, 0);
    b2.enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("sd_stay_idle", {b2.busy, b2.light}, 0);
    end
    b2.enable = 1'b1;
    tick(); check("sd_restart", b2.light, 4'b0001);

    // Pedestrian request in approach-0 green
    do_reset();
    b2.enable = 1'b1; b2.demand = 2'b11;
    tick();
    b2.ped_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      b2.ped_req = 1'b0;
      check($sformatf("ped_light[%0d]", i), b2.light, ped_light[i]);
      check($sformatf("ped_walk[%0d]", i), b2.walk, ped_walk[i]);
    end

    // Skip of empty phases on the 4-approach instance
    do_reset();
    b4.enable = 1'b1; b4.demand = 4'b1001;
    begin
      int  bad;
      bit  gprev, gnow;
      bad = 0; gprev = 0;
      served.delete();
      for (int c = 0; c < 24; c++) begin
        tick();
        if (b4.light[5:2] != 4'b0000) bad++;
        gnow = 0;
        for (int k = 0; k < 4; k++) if (b4.light[2*k +: 2] == 2'd1) gnow = 1;
        if (gnow && !gprev) served.push_back(b4.phase);
        gprev = gnow;
      end
      check("skip_mid_red", bad, 0);
      check("skip_count_ge4", served.size() >= 4, 1);
      for (int i = 0; i < 4; i++)
        if (i < served.size()) check($sformatf("skip_seq[%0d]", i), served[i], exp_srv[i]);
    end

    // Randomized run against the reference model
    do_reset();
    model_reset();
    begin
      bit         en, ped;
      logic [3:0] dem;
      dem = 4'b0001;
      for (int c = 0; c < 800; c++) begin
        en = ($urandom_range(0, 15) != 0);
        if ($urandom_range(0, 3) == 0) dem = 4'($urandom_range(0, 15));
        ped = ($urandom_range(0, 19) == 0);
        b4.enable = en; b4.demand = dem; b4.ped_req = ped;
        model_step(en, dem, ped);
        tick();
        check("rand_light", b4.light, model_light());
        check("rand_phase", b4.phase, m_ph);
        check("rand_walk", b4.walk, m_mode == MW);
        check("rand_busy", b4.busy, m_mode != MI);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
